// File: rtl/dfu_board_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dfu_board_pkg
// Brief   : Shared LED mode encodings and a width helper for dfu_board_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
package dfu_board_pkg;

  localparam logic [1:0] LED_OFF     = 2'd0;
  localparam logic [1:0] LED_ON      = 2'd1;
  localparam logic [1:0] LED_BLINK   = 2'd2;
  localparam logic [1:0] LED_BREATHE = 2'd3;

  // Bits needed to encode values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dfu_led_channel.sv
`default_nettype none
// ============================================================================
// Module  : dfu_led_channel
// Brief   : One status LED: mode select, activity flash counter, output flop.
// Rev     : 1.0  initial release
// ============================================================================
module dfu_led_channel
  import dfu_board_pkg::*;
#(
  parameter int ACT_CYCLES = 2400000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       core_reset,
  input  logic [1:0] mode,
  input  logic       activity,
  input  logic       blink_ph,
  input  logic       pwm,
  output logic       led
);

  localparam int FL_W = clog2(ACT_CYCLES + 1);
  localparam logic [FL_W-1:0] FL_MAX = FL_W'(ACT_CYCLES);

  logic [FL_W-1:0] r_flash_cnt;
  logic            r_led;
  logic            w_base;

  always_comb begin
    w_base = 1'b0;
    case (mode)
      LED_OFF:   w_base = 1'b0;
      LED_ON:    w_base = 1'b1;
      LED_BLINK: w_base = blink_ph;
      default:   w_base = pwm;
    endcase
  end

  // A strobe on the expiry cycle reloads, so back-to-back activity stays dark.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_flash_cnt <= '0;
      r_led       <= 1'b0;
    end else if (core_reset) begin
      r_flash_cnt <= '0;
      r_led       <= 1'b0;
    end else begin
      if (activity) begin
        r_flash_cnt <= FL_MAX;
      end else if (r_flash_cnt != '0) begin
        r_flash_cnt <= r_flash_cnt - FL_W'(1);
      end
      r_led <= (r_flash_cnt != '0) ? ~w_base : w_base;
    end
  end

  assign led = r_led;

endmodule
`default_nettype wire

// File: rtl/dfu_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dfu_board_ctrl
// Brief   : PLL-lock reset sequencer plus multi-channel status LED engine.
// Rev     : 1.0  initial release
// ============================================================================
module dfu_board_ctrl
  import dfu_board_pkg::*;
#(
  parameter int NUM_LEDS       = 1,
  parameter int RESET_CYCLES   = 32,
  parameter int BLINK_DIV_BITS = 23,
  parameter int PWM_BITS       = 8,
  parameter int ACT_CYCLES     = 2400000
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic                  pll_locked,
  output logic                  core_reset,
  input  logic [2*NUM_LEDS-1:0] led_mode,
  input  logic [NUM_LEDS-1:0]   activity,
  output logic [NUM_LEDS-1:0]   led
);

  localparam int RST_W = clog2(RESET_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_MAX = RST_W'(RESET_CYCLES);
  localparam int PAT_MSB = BLINK_DIV_BITS - 1;

  logic                      r_lock_meta;
  logic                      r_lock_s;
  logic [RST_W-1:0]          r_rst_cnt;
  logic                      r_core_reset;
  logic [BLINK_DIV_BITS-1:0] r_pat_cnt;

  logic                      w_blink_ph;
  logic [PWM_BITS-1:0]       w_tri;
  logic [PWM_BITS-1:0]       w_bright;
  logic                      w_pwm;
  logic                      w_pat_unused;

  // Lock loss gates core_reset straight from lock_s, one edge ahead of the
  // counter clear, so reassertion follows the synchroniser with no extra lag.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_lock_meta  <= 1'b0;
      r_lock_s     <= 1'b0;
      r_rst_cnt    <= '0;
      r_core_reset <= 1'b1;
      r_pat_cnt    <= '0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
      if (!r_lock_s) begin
        r_rst_cnt <= '0;
      end else if (r_rst_cnt != RST_MAX) begin
        r_rst_cnt <= r_rst_cnt + RST_W'(1);
      end
      r_core_reset <= !r_lock_s || (r_rst_cnt != RST_MAX);
      if (r_core_reset) begin
        r_pat_cnt <= '0;
      end else begin
        r_pat_cnt <= r_pat_cnt + BLINK_DIV_BITS'(1);
      end
    end
  end

  assign core_reset   = r_core_reset;
  assign w_blink_ph   = r_pat_cnt[PAT_MSB];
  assign w_tri        = r_pat_cnt[PAT_MSB-1 -: PWM_BITS];
  assign w_bright     = w_blink_ph ? ~w_tri : w_tri;
  assign w_pwm        = (r_pat_cnt[PWM_BITS-1:0] < w_bright);
  assign w_pat_unused = ^r_pat_cnt;

  generate
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
      dfu_led_channel #(
        .ACT_CYCLES (ACT_CYCLES)
      ) u_chan (
        .clk_48mhz  (clk_48mhz),
        .reset      (reset),
        .core_reset (r_core_reset),
        .mode       (led_mode[2*i +: 2]),
        .activity   (activity[i]),
        .blink_ph   (w_blink_ph),
        .pwm        (w_pwm),
        .led        (led[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dfu_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dfu_board_ctrl
// Brief   : Scoreboard bench for dfu_board_ctrl with directed vectors.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dfu_board_ctrl;
  import dfu_board_pkg::*;

  localparam int NUM_LEDS = 2;

  logic                  clk_48mhz = 1'b0;
  logic                  reset = 1'b1;
  logic                  pll_locked = 1'b1;
  logic [2*NUM_LEDS-1:0] led_mode = '0;
  logic [NUM_LEDS-1:0]   activity = '0;
  logic                  core_reset;
  logic [NUM_LEDS-1:0]   led;

  dfu_board_ctrl #(
    .NUM_LEDS       (NUM_LEDS),
    .RESET_CYCLES   (4),
    .BLINK_DIV_BITS (6),
    .PWM_BITS       (2),
    .ACT_CYCLES     (3)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .pll_locked (pll_locked),
    .core_reset (core_reset),
    .led_mode   (led_mode),
    .activity   (activity),
    .led        (led)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int cyc = 0;
  always @(posedge clk_48mhz) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       cr;
    logic [1:0] led;
    logic [1:0] mask;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t async_q[$];
  int   checks = 0;
  int   errors = 0;

  // Brightness per 8-cycle step of the 64-cycle pattern.
  int b_tab [8] = '{0, 1, 2, 3, 3, 2, 1, 0};

  task automatic push(input int c, input logic cr, input logic [1:0] l,
                      input logic [1:0] m, input string nm);
    exp_t e;
    e.cyc = c; e.cr = cr; e.led = l; e.mask = m; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_48mhz);
  endtask

  // Clocked monitor: compare every expectation tagged with the current edge.
  always @(negedge clk_48mhz) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || core_reset !== e.cr || (led & e.mask) !== (e.led & e.mask)) begin
        errors++;
        $display("FAIL %s edge=%0d now=%0d: got core_reset=%b led=%b, want core_reset=%b led=%b mask=%b",
                 e.name, e.cyc, cyc, core_reset, led, e.cr, e.led, e.mask);
      end
    end
  end

  // Asynchronous reset monitor: checked 1ns after reset rises, off any edge.
  always @(posedge reset) begin
    exp_t e;
    #1;
    if (async_q.size() > 0) begin
      e = async_q.pop_front();
      checks++;
      if (core_reset !== e.cr || led !== e.led) begin
        errors++;
        $display("FAIL %s: got core_reset=%b led=%b, want core_reset=%b led=%b",
                 e.name, core_reset, led, e.cr, e.led);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int rb, b, r, rb2, guard;
    exp_t e;
    logic l0, l1;

    // Startup with lock already high; activity during core_reset is ignored
    led_mode = {LED_ON, LED_ON};
    wait_cyc(3);
    push(4, 1'b1, 2'b00, 2'b11, "in_reset");
    push(5, 1'b1, 2'b00, 2'b11, "in_reset");
    wait_cyc(5);
    reset = 1'b0;
    rb = cyc;
    for (int k = 1; k <= 7; k++) push(rb + k, (k < 7), 2'b00, 2'b11, "startup");
    push(rb + 8, 1'b0, 2'b11, 2'b11, "ignore_act");
    push(rb + 9, 1'b0, 2'b11, 2'b11, "ignore_act");
    push(rb + 10, 1'b0, 2'b11, 2'b11, "run_on");
    push(rb + 11, 1'b0, 2'b11, 2'b11, "run_on");
    wait_cyc(rb + 6);
    activity = 2'b11;
    wait_cyc(rb + 7);
    activity = 2'b00;

    // One-cycle lock glitch
    b = rb + 12;
    wait_cyc(b);
    pll_locked = 1'b0;
    push(b + 1, 1'b0, 2'b00, 2'b00, "glitch");
    push(b + 2, 1'b0, 2'b00, 2'b00, "glitch");
    push(b + 3, 1'b1, 2'b00, 2'b00, "glitch_reassert");
    for (int k = 4; k <= 7; k++) push(b + k, 1'b1, 2'b00, 2'b11, "glitch_hold");
    push(b + 8, 1'b0, 2'b00, 2'b11, "glitch_release");
    wait_cyc(b + 1);
    pll_locked = 1'b1;
    led_mode = {LED_BREATHE, LED_BLINK};

    // Blink on ch0 and breathe on ch1 across a full pattern period
    r = b + 8;
    for (int k = 0; k <= 64; k++) begin
      l0 = ((k % 64) >= 32);
      l1 = ((k % 4) < b_tab[(k % 64) / 8]);
      push(r + 1 + k, 1'b0, {l1, l0}, 2'b11, "blink_breathe");
    end

    // Activity flash on a steady-on channel, then a retrigger at expiry
    wait_cyc(r + 66);
    led_mode = {LED_OFF, LED_ON};
    for (int c = r + 67; c <= r + 88; c++) begin
      l0 = !((c >= r + 72 && c <= r + 74) || (c >= r + 81 && c <= r + 86));
      push(c, 1'b0, {1'b0, l0}, 2'b11, "activity");
    end
    wait_cyc(r + 70); activity = 2'b01;
    wait_cyc(r + 71); activity = 2'b00;
    wait_cyc(r + 79); activity = 2'b01;
    wait_cyc(r + 80); activity = 2'b00;
    wait_cyc(r + 82); activity = 2'b01;
    wait_cyc(r + 83); activity = 2'b00;

    // Asynchronous reset while blinking and flashing
    wait_cyc(r + 88);
    led_mode = {LED_ON, LED_BLINK};
    activity = 2'b01;
    push(r + 89, 1'b0, 2'b10, 2'b11, "pre_reset");
    push(r + 90, 1'b0, 2'b11, 2'b11, "pre_reset_flash");
    wait_cyc(r + 89);
    activity = 2'b00;
    wait_cyc(r + 90);
    push(r + 91, 1'b1, 2'b00, 2'b11, "held_reset");
    push(r + 92, 1'b1, 2'b00, 2'b11, "held_reset");
    e.cyc = 0; e.cr = 1'b1; e.led = 2'b00; e.mask = 2'b11; e.name = "async_reset";
    async_q.push_back(e);
    #2;
    reset = 1'b1;
    wait_cyc(r + 92);
    reset = 1'b0;
    rb2 = cyc;
    for (int k = 1; k <= 7; k++) push(rb2 + k, (k < 7), 2'b00, 2'b11, "restart");
    push(rb2 + 8, 1'b0, 2'b10, 2'b11, "restart_run");
    push(rb2 + 9, 1'b0, 2'b10, 2'b11, "restart_run");
    wait_cyc(rb2 + 10);

    guard = 0;
    while ((exp_q.size() > 0 || async_q.size() > 0) && guard < 100) begin
      @(negedge clk_48mhz);
      guard++;
    end
    if (exp_q.size() > 0 || async_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size() + async_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
